// File: rtl/onchip_mem_pkg.sv
// Shared types and constants for the pipelined on-chip memory slave.
package onchip_mem_pkg;

    // Deepest read pipeline supported (RAM register plus one output stage).
    localparam int MAX_READ_LATENCY = 2;

    // Controller states: serving the bus, or filling the RAM with INIT_VALUE.
    typedef enum logic [0:0] {
        READY = 1'b0,
        CLEAR = 1'b1
    } mem_state_e;

    // Number of byte lanes in a data word.
    function automatic int byte_lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/onchip_ram_core.sv
// Single-port RAM with per-byte write enables and a one-cycle registered read.
// Addresses at or beyond DEPTH are never written and read back as zero.
module onchip_ram_core
    import onchip_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16384,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int NB     = byte_lanes(DATA_W)
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [NB-1:0]     i_be,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic              w_in_range;

    assign w_in_range = ({1'b0, i_addr} < DEPTH_C);
    assign o_rdata    = r_rdata;

    // Byte-lane write; out-of-range addresses are dropped.
    always_ff @(posedge clk) begin
        if (i_en && i_we && w_in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Registered read port; holds its value between reads.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_en && i_re) begin
            r_rdata <= w_in_range ? r_mem[i_addr] : '0;
        end
    end

endmodule

// File: rtl/onchip_memory_pipelined.sv
// Avalon-MM on-chip RAM slave with configurable read latency and a
// hardware clear engine that fills the array with INIT_VALUE.
module onchip_memory_pipelined
    import onchip_mem_pkg::*;
#(
    parameter int              DATA_W       = 32,
    parameter int              DEPTH        = 16384,
    parameter int              READ_LATENCY = 1,
    parameter int              INIT_CLEAR   = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int NB     = byte_lanes(DATA_W)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [NB-1:0]     byteenable,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid,
    output logic              waitrequest,
    input  logic              clken,
    input  logic              freeze,
    input  logic              init_start,
    output logic              init_busy
);

    localparam bit          TWO_STAGE = (READ_LATENCY >= MAX_READ_LATENCY);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    mem_state_e        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_init_busy;
    logic              r_pending;
    logic              r_v1;
    logic              r_v2;
    logic [DATA_W-1:0] r_data2;

    logic              w_accept;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_inflight;
    logic              w_ram_we;
    logic              w_ram_re;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [NB-1:0]     w_ram_be;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [DATA_W-1:0] w_ram_rdata;

    // Command acceptance never looks at read/write, so waitrequest is stable.
    assign waitrequest = r_init_busy | ~clken | freeze | r_pending;
    assign w_accept    = chipselect & (read | write) & ~waitrequest;
    assign w_wr_acc    = w_accept & write;
    assign w_rd_acc    = w_accept & read & ~write;
    assign w_inflight  = r_v1 | r_v2 | w_rd_acc;

    assign init_busy     = r_init_busy;
    assign readdata      = TWO_STAGE ? r_data2 : w_ram_rdata;
    assign readdatavalid = (TWO_STAGE ? r_v2 : r_v1) & clken;

    // RAM port ownership: the clear engine while clearing, the bus otherwise.
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_re    = 1'b0;
        w_ram_addr  = address;
        w_ram_be    = byteenable;
        w_ram_wdata = writedata;
        if (r_state == CLEAR) begin
            w_ram_we    = 1'b1;
            w_ram_addr  = r_ptr;
            w_ram_be    = '1;
            w_ram_wdata = INIT_VALUE;
        end else begin
            w_ram_we = w_wr_acc;
            w_ram_re = w_rd_acc;
        end
    end

    onchip_ram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk     (clk),
        .i_rst_n (reset_n),
        .i_en    (clken),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_ram_addr),
        .i_be    (w_ram_be),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Clear FSM: walks ptr over the array, defers a requested clear until reads drain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= (INIT_CLEAR != 0) ? CLEAR : READY;
            r_init_busy <= (INIT_CLEAR != 0);
            r_ptr       <= '0;
            r_pending   <= 1'b0;
        end else if (clken) begin
            case (r_state)
                CLEAR: begin
                    if (r_ptr == LAST_ADDR) begin
                        r_state     <= READY;
                        r_init_busy <= 1'b0;
                        r_ptr       <= '0;
                    end else begin
                        r_ptr <= r_ptr + ADDR_W'(1);
                    end
                end
                READY: begin
                    if (r_pending || init_start) begin
                        if (!w_inflight) begin
                            r_state     <= CLEAR;
                            r_init_busy <= 1'b1;
                            r_ptr       <= '0;
                            r_pending   <= 1'b0;
                        end else begin
                            r_pending <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= READY;
                    r_init_busy <= 1'b0;
                    r_ptr       <= '0;
                    r_pending   <= 1'b0;
                end
            endcase
        end
    end

    // Read latency pipeline; frozen as a whole while clken is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_data2 <= '0;
        end else if (clken) begin
            r_v1 <= w_rd_acc;
            r_v2 <= TWO_STAGE ? r_v1 : 1'b0;
            if (TWO_STAGE && r_v1) begin
                r_data2 <= w_ram_rdata;
            end
        end
    end

endmodule

// File: doc/onchip_memory_pipelined.md
Name: onchip_memory_pipelined

Overview:
Parametrised on-chip RAM with an Avalon-MM slave interface. It is the successor to the fixed 32-bit x 16384, single-cycle, unregistered on-chip memory slave.
- Adds configurable width, depth and read latency.
- Adds explicit read / readdatavalid / waitrequest handshaking.
- Adds a hardware clear engine that fills the RAM with a known value after reset or on request.
- Sits on the Nios system interconnect as instruction/data memory.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- DEPTH, 16384, number of words; need not be a power of two.
- ADDR_W, $clog2(DEPTH), word-address width; derived, not overridden.
- READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal values are 1 or 2 (2 adds an output register).
- INIT_CLEAR, 1, when 1 the RAM is cleared automatically after reset deassertion.
- INIT_VALUE, 0, DATA_W-bit word written by the clear engine.

Ports:
- clk  in  1  system clock; the single clock domain.
- reset_n  in  1  asynchronous active-low reset.
- address  in  ADDR_W  word address.
- byteenable  in  DATA_W/8  per-byte write enables.
- chipselect  in  1  slave select.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  DATA_W  write data.
- readdata  out  DATA_W  read data; valid only when readdatavalid=1.
- readdatavalid  out  1  one-cycle pulse per accepted read.
- waitrequest  out  1  command not accepted this cycle.
- clken  in  1  clock enable; 0 stalls the block.
- freeze  in  1  1 blocks new commands.
- init_start  in  1  pulse that requests a clear.
- init_busy  out  1  clear in progress.

Behaviour:
- Reset values: readdata=0, readdatavalid=0, init_busy=INIT_CLEAR, waitrequest=INIT_CLEAR, clear pointer=0, latency pipeline empty. RAM contents are not reset.
- FSM states are READY and CLEAR.
  - On reset release, the FSM enters CLEAR if INIT_CLEAR=1, otherwise READY.
  - CLEAR: each cycle with clken=1 writes INIT_VALUE to address ptr with all byte enables set, then increments ptr.
  - CLEAR -> READY after writing DEPTH-1. The last write and the transition happen in the same cycle. init_busy falls on the following edge.
  - READY -> CLEAR, with ptr=0, when init_start=1 and no read is in flight. If a read is in flight, init_start is latched and acted on once the pipeline drains.
  - init_start during CLEAR is ignored.
- waitrequest = init_busy | ~clken | freeze | pending_clear. It is combinational from these registered/input terms and never depends on read/write.
- Accept condition: chipselect & (read|write) & ~waitrequest.
- If read and write are both set, the cycle is a write only: no readdatavalid, and the read is dropped.
- Write: the selected bytes at address are updated at the accepting edge. A read accepted on the next cycle returns the new data.
- Read, READ_LATENCY=1: readdata and readdatavalid are registered on the edge after acceptance.
- Read, READ_LATENCY=2: one extra register stage. Back-to-back reads are accepted every cycle, giving full throughput.
- clken=0 freezes everything: FSM, clear pointer, RAM port and latency pipeline. readdatavalid is forced to 0 during the stall. A valid beat held in the pipeline is presented on the first clken=1 cycle.
- freeze=1 only blocks new commands. Reads already in flight complete, and a clear in progress continues.
- Out-of-range address (address >= DEPTH): writes are discarded; reads return 0 with a normal readdatavalid.
- reset_n asserted mid-clear or mid-read: all in-flight state is discarded and the reset values apply. After release with INIT_CLEAR=1, the clear restarts from address 0.

Decomposition:
- Package onchip_mem_pkg holds:
  - the state enum (READY, CLEAR);
  - the function computing byte-lane count;
  - constant MAX_READ_LATENCY=2.
- One sub-module, onchip_ram_core: an inferred single-port RAM with byte-enable write and a one-cycle registered read, parametrised by DATA_W/DEPTH.
- The top level contains the FSM, clear pointer, arbitration and latency pipeline.

Test Plan:
- Reset release with INIT_CLEAR=1, DEPTH=64 -> waitrequest=1 for exactly 64 clken cycles, then 0. A read of address 5 returns 0x00000000 with readdatavalid one cycle (L=1) after acceptance.
- Write 0xDEADBEEF to address 3 with byteenable=4'b0101, then read address 3 -> 0x00AD00EF (pre-cleared memory). readdatavalid occurs 2 cycles after acceptance when READ_LATENCY=2.
- Back-to-back reads of addresses 0,1,2,3 with READ_LATENCY=2 -> four consecutive readdatavalid pulses carrying the stored values in order. waitrequest stays 0 throughout.
- read=write=1 to address 7 with data 0x12345678 -> no readdatavalid; a subsequent read of address 7 returns 0x12345678.
- clken dropped for 3 cycles with a read in flight -> readdatavalid stays 0 during the stall, then a single pulse carries the correct data on clken return.
- init_start pulsed in READY, then reset_n asserted at ptr=20 -> after release, init_busy=1 and the clear restarts at 0. All 64 words read back INIT_VALUE.
